// File: rtl/iob_cache_traffic_gen.sv
// IOb Native self-test master: writes an arithmetic pattern over N words,
// waits for the cache write-through buffer to drain, then reads back and checks.
module iob_cache_traffic_gen #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4,
  parameter int DATA_MUL  = 3
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      n_words_i,
  input  logic                  wtb_empty_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [CNT_W-1:0]      err_cnt_o,
  output logic [ADDR_W-1:0]     first_err_addr_o,
  output logic                  iob_valid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  localparam logic [DATA_W-1:0] MUL  = DATA_W'(DATA_MUL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_DRAIN,
    S_RD,
    S_RWAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;

  logic [ADDR_W-1:0]   addr_k;
  logic [DATA_W-1:0]   data_k;
  logic                last_k;
  logic                accept;

  // Address and pattern are pure functions of k, so they stay stable while k holds.
  always_comb begin
    addr_k = ADDR_W'(k_q) * STEP;
    data_k = DATA_W'(addr_k) * MUL;
    last_k = (k_q == n_q - CNT_W'(1));
  end

  assign iob_valid_o = (state_q == S_WR) || (state_q == S_RD);
  assign accept      = iob_valid_o && iob_ready_i;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    err_d   = err_q;
    first_d = first_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          n_d     = n_words_i;
          k_d     = '0;
          err_d   = '0;
          first_d = '0;
          state_d = (n_words_i == '0) ? S_DONE : S_WR;
        end
      end

      S_WR: begin
        if (accept) begin
          if (last_k) begin
            k_d     = '0;
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + CNT_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (wtb_empty_i) begin
          state_d = S_RD;
        end
      end

      S_RD: begin
        if (accept) begin
          state_d = S_RWAIT;
        end
      end

      S_RWAIT: begin
        if (iob_rvalid_i) begin
          if (iob_rdata_i != data_k) begin
            if (err_q != '1) begin
              err_d = err_q + CNT_W'(1);
            end
            if (err_q == '0) begin
              first_d = addr_k;
            end
          end
          if (last_k) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + CNT_W'(1);
            state_d = S_RD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign iob_addr_o       = iob_valid_o ? addr_k : '0;
  assign iob_wdata_o      = (state_q == S_WR) ? data_k : '0;
  assign iob_wstrb_o      = (state_q == S_WR) ? '1 : '0;
  assign busy_o           = (state_q == S_WR) || (state_q == S_DRAIN) ||
                            (state_q == S_RD) || (state_q == S_RWAIT);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = done_o && (err_q == '0);
  assign err_cnt_o        = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_iob_cache_traffic_gen.sv
// Scoreboard bench for iob_cache_traffic_gen: a memory model answers the IOb
// requests, expected writes/reads are queued per run and popped on acceptance.
module tb_iob_cache_traffic_gen;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] n_words = '0;
  logic        wtb_empty = 1'b1;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [23:0] first_err;
  logic        iob_valid;
  logic [23:0] iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready = 1'b1;
  logic        iob_rvalid = 1'b0;
  logic [31:0] iob_rdata = '0;

  iob_cache_traffic_gen #(
    .ADDR_W(24), .DATA_W(32), .CNT_W(16), .ADDR_STEP(4), .DATA_MUL(3)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .start_i(start), .n_words_i(n_words),
    .wtb_empty_i(wtb_empty), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_cnt_o(err_cnt), .first_err_addr_o(first_err),
    .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
    .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready),
    .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [23:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [23:0] exp_rd[$];
  logic [31:0] mem [0:255];

  int  wr_seen, rd_seen, valid_seen;
  int  stall_wr_idx = -1, stall_rd_idx = -1;
  int  stall_wr_rem, stall_rd_rem;
  int  drain_hold = 0, drain_cnt = 0;
  int  gap_cnt = 0;
  bit  gap_armed = 0, corrupt_en = 0, spurious_en = 0;
  bit  rd_pending = 0, prev_stall = 0;
  logic [23:0] pend_addr, prev_addr;
  logic [31:0] prev_wdata;
  logic [3:0]  prev_wstrb;

  // Memory / cache-frontend model: decides ready at the negedge for the coming posedge.
  always @(negedge clk) begin
    if (!arst_n) begin
      iob_rvalid = 1'b0;
      iob_ready  = 1'b1;
      rd_pending = 0;
      prev_stall = 0;
      drain_cnt  = 0;
      wtb_empty  = 1'b1;
      gap_armed  = 0;
    end else begin
      if (gap_armed) gap_cnt++;
      if (drain_cnt > 0) drain_cnt--;
      wtb_empty  = (drain_cnt == 0);
      iob_rvalid = 1'b0;
      if (rd_pending) begin
        iob_rvalid = 1'b1;
        iob_rdata  = mem[pend_addr[9:2]];
        if (corrupt_en && pend_addr == 24'd8)  iob_rdata = 32'd25;
        if (corrupt_en && pend_addr == 24'd16) iob_rdata = iob_rdata ^ 32'd1;
        rd_pending = 0;
      end else if (spurious_en && drain_cnt > 0) begin
        iob_rvalid = 1'b1;
        iob_rdata  = 32'hdead_beef;
      end
      if (prev_stall) begin
        check_eq("hold_valid", iob_valid, 1);
        check_eq("hold_addr",  iob_addr,  prev_addr);
        check_eq("hold_wdata", iob_wdata, prev_wdata);
        check_eq("hold_wstrb", iob_wstrb, prev_wstrb);
      end
      prev_stall = 0;
      iob_ready  = 1'b1;
      if (iob_valid) begin
        valid_seen++;
        if (iob_wstrb != '0) begin
          if (wr_seen == stall_wr_idx && stall_wr_rem > 0) begin
            iob_ready = 1'b0;
            stall_wr_rem--;
          end
        end else begin
          if (gap_armed) begin
            check_eq("drain_gap", gap_cnt, ((drain_hold == 0) ? 1 : drain_hold) + 1);
            gap_armed = 0;
          end
          if (rd_seen == stall_rd_idx && stall_rd_rem > 0) begin
            iob_ready = 1'b0;
            stall_rd_rem--;
          end
        end
        if (!iob_ready) begin
          prev_stall = 1;
          prev_addr  = iob_addr;
          prev_wdata = iob_wdata;
          prev_wstrb = iob_wstrb;
        end else if (iob_wstrb != '0) begin
          check_eq("wr_strb", iob_wstrb, 4'hf);
          if (exp_wr.size() == 0) begin
            check_eq("wr_extra", iob_addr, 24'hffffff);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            check_eq("wr_addr", iob_addr, e.a);
            check_eq("wr_data", iob_wdata, e.d);
          end
          mem[iob_addr[9:2]] = iob_wdata;
          wr_seen++;
          if (exp_wr.size() == 0) begin
            drain_cnt = drain_hold;
            wtb_empty = (drain_hold == 0);
            gap_armed = 1;
            gap_cnt   = 0;
          end
        end else begin
          if (exp_rd.size() == 0) begin
            check_eq("rd_extra", iob_addr, 24'hffffff);
          end else begin
            check_eq("rd_addr", iob_addr, exp_rd.pop_front());
          end
          rd_pending = 1;
          pend_addr  = iob_addr;
          rd_seen++;
        end
      end
    end
  end

  task automatic prep(input int n, input int hold, input bit corrupt,
                      input int swr, input int srd, input bit spur);
    logic [23:0] a;
    exp_wr.delete();
    exp_rd.delete();
    for (int k = 0; k < n; k++) begin
      wr_t e;
      a   = 24'(k * 4);
      e.a = a;
      e.d = 32'(a) * 32'd3;
      exp_wr.push_back(e);
      exp_rd.push_back(a);
    end
    drain_hold   = hold;
    corrupt_en   = corrupt;
    spurious_en  = spur;
    stall_wr_idx = swr;
    stall_rd_idx = srd;
    stall_wr_rem = 3;
    stall_rd_rem = 3;
    wr_seen      = 0;
    rd_seen      = 0;
    valid_seen   = 0;
  endtask

  task automatic run_test(input string name, input int n, input int hold, input bit corrupt,
                          input int swr, input int srd, input bit spur, input bit mid_start,
                          input int exp_err, input logic [23:0] exp_first);
    int cyc;
    prep(n, hold, corrupt, swr, srd, spur);
    @(negedge clk);
    start   = 1'b1;
    n_words = 16'(n);
    @(negedge clk);
    start   = 1'b0;
    n_words = 16'hffff;
    #1;
    check_eq({name, "_first_valid"}, iob_valid, (n != 0));
    check_eq({name, "_busy"}, busy, (n != 0));
    if (n == 0) check_eq({name, "_zero_done"}, done, 1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (mid_start && cyc == 4) begin
        start   = 1'b1;
        n_words = 16'd7;
      end
      if (mid_start && cyc == 6) start = 1'b0;
      @(negedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check_eq({name, "_done"}, done, 1);
    check_eq({name, "_busy_end"}, busy, 0);
    check_eq({name, "_pass"}, pass, (exp_err == 0));
    check_eq({name, "_err_cnt"}, err_cnt, 16'(exp_err));
    check_eq({name, "_first_err"}, first_err, exp_first);
    check_eq({name, "_wr_left"}, exp_wr.size(), 0);
    check_eq({name, "_rd_left"}, exp_rd.size(), 0);
    if (n == 0) check_eq({name, "_no_valid"}, valid_seen, 0);
    repeat (3) @(negedge clk);
    #1;
    check_eq({name, "_done_hold"}, done, 1);
  endtask

  initial begin
    int cyc;
    #1;
    check_eq("rst_valid", iob_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_err", err_cnt, 0);
    check_eq("rst_first", first_err, 0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;

    run_test("basic",   5,  0, 0, -1, -1, 0, 0, 0, 24'd0);
    run_test("stall",   5,  0, 0,  1,  3, 0, 0, 0, 24'd0);
    run_test("corrupt", 5,  0, 1, -1, -1, 0, 0, 2, 24'd8);
    run_test("drain",   5, 10, 0, -1, -1, 1, 0, 0, 24'd0);
    run_test("zero",    0,  0, 0, -1, -1, 0, 0, 0, 24'd0);
    run_test("one",     1,  1, 0, -1, -1, 0, 0, 0, 24'd0);
    run_test("midstart",6,  0, 0, -1, -1, 0, 1, 0, 24'd0);

    // Reset while the third write is being presented.
    prep(5, 0, 0, -1, -1, 0);
    @(negedge clk);
    start   = 1'b1;
    n_words = 16'd5;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (wr_seen < 3 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("rst_mid_reached", wr_seen, 3);
    check_eq("rst_mid_pre_valid", iob_valid, 1);
    #1 arst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", iob_valid, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_done", done, 0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_mid_valid_held", iob_valid, 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_mid_idle", busy, 0);
    run_test("after_rst", 5, 0, 0, -1, -1, 0, 0, 0, 24'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
